// File: rtl/ysyx_22040125_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 size codes,
// FSM state encoding and the architectural reset PC.
package ysyx_22040125_lsu_pkg;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_22040125_lsu_align.sv
// Combinational lane logic: access-fault check and store lane placement for the
// incoming instruction, plus load lane extraction and extension for the response.
module ysyx_22040125_lsu_align
  import ysyx_22040125_lsu_pkg::*;
(
  input  logic [2:0]  req_off_i,
  input  logic [2:0]  req_funct3_i,
  input  logic        req_mem_rd_i,
  input  logic        req_mem_wr_i,
  input  logic [63:0] req_wdata_i,
  output logic        fault_o,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb_o,
  input  logic [2:0]  rsp_off_i,
  input  logic [2:0]  rsp_funct3_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] rdata_o
);

  logic        misaligned;
  logic [7:0]  strb_base;
  logic [63:0] rsp_shifted;

  // The low two funct3 bits encode access size for both signed and unsigned forms.
  always_comb begin
    misaligned = 1'b0;
    strb_base  = 8'h00;
    case (req_funct3_i[1:0])
      2'b00: begin
        misaligned = 1'b0;
        strb_base  = 8'h01;
      end
      2'b01: begin
        misaligned = req_off_i[0];
        strb_base  = 8'h03;
      end
      2'b10: begin
        misaligned = |req_off_i[1:0];
        strb_base  = 8'h0F;
      end
      default: begin
        misaligned = |req_off_i;
        strb_base  = 8'hFF;
      end
    endcase
  end

  always_comb begin
    fault_o = (req_mem_rd_i || req_mem_wr_i) &&
              (misaligned || (req_funct3_i == F3_BAD) || (req_mem_rd_i && req_mem_wr_i));
    wstrb_o = strb_base << req_off_i;
    wdata_o = req_wdata_i << {req_off_i, 3'b000};
  end

  always_comb begin
    rsp_shifted = rdata_i >> {rsp_off_i, 3'b000};
    case (rsp_funct3_i)
      F3_B:    rdata_o = {{56{rsp_shifted[7]}}, rsp_shifted[7:0]};
      F3_H:    rdata_o = {{48{rsp_shifted[15]}}, rsp_shifted[15:0]};
      F3_W:    rdata_o = {{32{rsp_shifted[31]}}, rsp_shifted[31:0]};
      F3_BU:   rdata_o = {56'd0, rsp_shifted[7:0]};
      F3_HU:   rdata_o = {48'd0, rsp_shifted[15:0]};
      F3_WU:   rdata_o = {32'd0, rsp_shifted[31:0]};
      default: rdata_o = rsp_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// Memory-stage load/store unit: accepts one instruction at a time, runs aligned
// accesses on a req/gnt/rvalid bus and registers a single-cycle result pulse.
module ysyx_22040125_lsu
  import ysyx_22040125_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_alu,
  input  logic [63:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_rd,
  input  logic        in_mem_wr,
  input  logic        in_reg_we,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [63:0] dbus_addr,
  output logic [63:0] dbus_wdata,
  output logic [7:0]  dbus_wstrb,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [63:0] dbus_rdata,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [4:0]  out_rd,
  output logic [63:0] out_data,
  output logic        out_reg_we,
  output logic        out_err
);

  state_e      state_q, state_d;

  logic [63:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic        reg_we_q, reg_we_d;

  logic        bus_we_q, bus_we_d;
  logic [63:0] bus_addr_q, bus_addr_d;
  logic [63:0] bus_wdata_q, bus_wdata_d;
  logic [7:0]  bus_wstrb_q, bus_wstrb_d;

  logic        out_valid_q, out_valid_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_reg_we_q, out_reg_we_d;
  logic        out_err_q, out_err_d;

  logic        accept;
  logic        is_mem;
  logic        fault;
  logic        done;
  logic [63:0] lane_wdata;
  logic [7:0]  lane_wstrb;
  logic [63:0] load_data;

  ysyx_22040125_lsu_align u_align (
    .req_off_i    (in_alu[2:0]),
    .req_funct3_i (in_funct3),
    .req_mem_rd_i (in_mem_rd),
    .req_mem_wr_i (in_mem_wr),
    .req_wdata_i  (in_wdata),
    .fault_o      (fault),
    .wdata_o      (lane_wdata),
    .wstrb_o      (lane_wstrb),
    .rsp_off_i    (off_q),
    .rsp_funct3_i (funct3_q),
    .rdata_i      (dbus_rdata),
    .rdata_o      (load_data)
  );

  assign in_ready = rst && (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_mem_rd || in_mem_wr;
  // Responses only count while a request is actually outstanding.
  assign done     = ((state_q == REQ) && dbus_gnt && dbus_rvalid) ||
                    ((state_q == WAIT) && dbus_rvalid);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rd_d         = rd_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    is_store_d   = is_store_q;
    reg_we_d     = reg_we_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    out_valid_d  = 1'b0;
    out_pc_d     = out_pc_q;
    out_rd_d     = out_rd_q;
    out_data_d   = out_data_q;
    out_reg_we_d = out_reg_we_q;
    out_err_d    = out_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem || fault) begin
            out_valid_d  = 1'b1;
            out_pc_d     = in_pc;
            out_rd_d     = in_rd;
            out_data_d   = in_alu;
            out_reg_we_d = !fault && in_reg_we && (in_rd != 5'd0);
            out_err_d    = fault;
          end else begin
            state_d     = REQ;
            pc_d        = in_pc;
            rd_d        = in_rd;
            off_d       = in_alu[2:0];
            funct3_d    = in_funct3;
            is_store_d  = in_mem_wr;
            reg_we_d    = in_reg_we;
            bus_we_d    = in_mem_wr;
            bus_addr_d  = {in_alu[63:3], 3'b000};
            bus_wdata_d = lane_wdata;
            bus_wstrb_d = lane_wstrb;
          end
        end
      end
      REQ: begin
        if (dbus_gnt) begin
          state_d = dbus_rvalid ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (dbus_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      out_valid_d  = 1'b1;
      out_pc_d     = pc_q;
      out_rd_d     = rd_q;
      out_data_d   = is_store_q ? 64'd0 : load_data;
      out_reg_we_d = !is_store_q && reg_we_q && (rd_q != 5'd0);
      out_err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= 64'd0;
      rd_q         <= 5'd0;
      off_q        <= 3'd0;
      funct3_q     <= 3'd0;
      is_store_q   <= 1'b0;
      reg_we_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 64'd0;
      bus_wdata_q  <= 64'd0;
      bus_wstrb_q  <= 8'd0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= RESET_PC;
      out_rd_q     <= 5'd0;
      out_data_q   <= 64'd0;
      out_reg_we_q <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_q         <= rd_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      is_store_q   <= is_store_d;
      reg_we_q     <= reg_we_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_rd_q     <= out_rd_d;
      out_data_q   <= out_data_d;
      out_reg_we_q <= out_reg_we_d;
      out_err_q    <= out_err_d;
    end
  end

  assign dbus_req   = (state_q == REQ);
  assign dbus_we    = bus_we_q;
  assign dbus_addr  = bus_addr_q;
  assign dbus_wdata = bus_wdata_q;
  assign dbus_wstrb = bus_wstrb_q;

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_rd     = out_rd_q;
  assign out_data   = out_data_q;
  assign out_reg_we = out_reg_we_q;
  assign out_err    = out_err_q;

endmodule
